// File: rtl/decode_stage.sv
// decode_stage: RV32I/Zicsr decode pipeline stage with hazard scoreboard
package instruction;
   typedef enum logic [5:0] {
      LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LBU, LHU, SB, SH, SW,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      FENCE, FENCE_I, ECALL, EBREAK, MRET, WFI,
      CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI, ILLEGAL
   } op_e;
   typedef struct packed {
      op_e         op;
      logic [4:0]  rd_address;
      logic [4:0]  rs1_address;
      logic [4:0]  rs2_address;
      logic [31:0] immediate;
      logic [11:0] csr;
   } t;
endpackage

// instruction_decoder: combinational RV32I/Zicsr decode; register fields are passed through raw
module instruction_decoder
   import instruction::*;
(
   input  logic [31:0] instruction_i,
   output t            decoded_o
);
   logic [31:0] w, imm, imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [2:0]  f3;
   logic [6:0]  f7;
   op_e         op;
   assign w     = instruction_i;
   assign f3    = w[14:12];
   assign f7    = w[31:25];
   assign imm_i = {{20{w[31]}}, w[31:20]};
   assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
   assign imm_b = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
   assign imm_u = {w[31:12], 12'b0};
   assign imm_j = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
   // Pick the operation and its format-specific immediate from opcode and function fields
   always_comb begin
      op  = ILLEGAL;
      imm = imm_i;
      case (w[6:0])
         7'h37: begin op = LUI; imm = imm_u; end
         7'h17: begin op = AUIPC; imm = imm_u; end
         7'h6F: begin op = JAL; imm = imm_j; end
         7'h67: op = (f3 == 3'd0) ? JALR : ILLEGAL;
         7'h63: begin
            imm = imm_b;
            case (f3)
               3'd0: op = BEQ;
               3'd1: op = BNE;
               3'd4: op = BLT;
               3'd5: op = BGE;
               3'd6: op = BLTU;
               3'd7: op = BGEU;
               default: op = ILLEGAL;
            endcase
         end
         7'h03: begin
            case (f3)
               3'd0: op = LB;
               3'd1: op = LH;
               3'd2: op = LW;
               3'd4: op = LBU;
               3'd5: op = LHU;
               default: op = ILLEGAL;
            endcase
         end
         7'h23: begin
            imm = imm_s;
            op  = (f3 == 3'd0) ? SB : (f3 == 3'd1) ? SH : (f3 == 3'd2) ? SW : ILLEGAL;
         end
         7'h13: begin
            case (f3)
               3'd0: op = ADDI;
               3'd1: op = (f7 == 7'h00) ? SLLI : ILLEGAL;
               3'd2: op = SLTI;
               3'd3: op = SLTIU;
               3'd4: op = XORI;
               3'd5: op = (f7 == 7'h00) ? SRLI : (f7 == 7'h20) ? SRAI : ILLEGAL;
               3'd6: op = ORI;
               default: op = ANDI;
            endcase
         end
         7'h33: begin
            case ({f7, f3})
               10'h000: op = ADD;
               10'h100: op = SUB;
               10'h001: op = SLL;
               10'h002: op = SLT;
               10'h003: op = SLTU;
               10'h004: op = XOR;
               10'h005: op = SRL;
               10'h105: op = SRA;
               10'h006: op = OR;
               10'h007: op = AND;
               default: op = ILLEGAL;
            endcase
         end
         7'h0F: op = (f3 == 3'd0) ? FENCE : (f3 == 3'd1) ? FENCE_I : ILLEGAL;
         7'h73: begin
            if (f3[2]) imm = {27'b0, w[19:15]};
            case (f3)
               3'd0: op = (w == 32'h00000073) ? ECALL :
                          (w == 32'h00100073) ? EBREAK :
                          (w == 32'h30200073) ? MRET :
                          (w == 32'h10500073) ? WFI : ILLEGAL;
               3'd1: op = CSRRW;
               3'd2: op = CSRRS;
               3'd3: op = CSRRC;
               3'd5: op = CSRRWI;
               3'd6: op = CSRRSI;
               3'd7: op = CSRRCI;
               default: op = ILLEGAL;
            endcase
         end
         default: op = ILLEGAL;
      endcase
   end
   assign decoded_o = '{op: op, rd_address: w[11:7], rs1_address: w[19:15],
                        rs2_address: w[24:20], immediate: imm, csr: w[31:20]};
endmodule

// decode_stage: one-entry decoded-instruction register gated by a 32-bit busy scoreboard
module decode_stage #(
   parameter int COUNTER_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_valid,
   output logic                     fetch_ready,
   input  logic [31:0]              fetch_instruction,
   input  logic [31:0]              fetch_pc,
   input  logic                     flush,
   output logic                     issue_valid,
   input  logic                     issue_ready,
   output instruction::t            issue_instruction,
   output logic [31:0]              issue_pc,
   input  logic                     writeback_valid,
   input  logic [4:0]               writeback_rd,
   output logic [COUNTER_WIDTH-1:0] stall_count
);
   import instruction::*;
   t                   decoded, held_q;
   logic               held_valid_q, held_valid_d, hazard, serial, stall_inc;
   logic               fetch_fire, issue_fire;
   logic [31:0]        pc_q, busy_q, busy_d, set_mask, clr_mask;
   logic [COUNTER_WIDTH-1:0] stall_q, stall_d;
   instruction_decoder u_dec (.instruction_i(fetch_instruction), .decoded_o(decoded));
   assign serial = held_q.op inside {CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
                                     FENCE, FENCE_I, ECALL, EBREAK, MRET, WFI};
   // Address fields are checked even when the op ignores them: conservative but simple
   assign hazard = (held_q.op != ILLEGAL) &&
                   ((|held_q.rs1_address && busy_q[held_q.rs1_address]) ||
                    (|held_q.rs2_address && busy_q[held_q.rs2_address]) ||
                    (|held_q.rd_address  && busy_q[held_q.rd_address])  ||
                    (serial && |busy_q));
   assign issue_valid  = held_valid_q && !hazard && !flush && !rst;
   assign issue_fire   = issue_valid && issue_ready;
   assign fetch_ready  = !rst && !flush && (!held_valid_q || issue_fire);
   assign fetch_fire   = fetch_valid && fetch_ready;
   assign held_valid_d = flush ? 1'b0 : fetch_fire ? 1'b1 : issue_fire ? 1'b0 : held_valid_q;
   assign set_mask     = (issue_fire && |held_q.rd_address && held_q.op != ILLEGAL) ?
                         32'd1 << held_q.rd_address : 32'd0;
   assign clr_mask     = writeback_valid ? 32'd1 << writeback_rd : 32'd0;
   assign busy_d       = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
   assign stall_inc    = held_valid_q && hazard && !flush;
   assign stall_d      = stall_q + {{(COUNTER_WIDTH-1){1'b0}}, stall_inc};
   assign issue_instruction = held_q;
   assign issue_pc          = pc_q;
   assign stall_count       = stall_q;
   // Stage register, scoreboard and stall counter; flush leaves the scoreboard intact
   always_ff @(posedge clk) begin
      if (rst) begin
         held_valid_q <= 1'b0;
         held_q       <= '0;
         pc_q         <= '0;
         busy_q       <= '0;
         stall_q      <= '0;
      end else begin
         held_valid_q <= held_valid_d;
         busy_q       <= busy_d;
         stall_q      <= stall_d;
         if (fetch_fire) begin
            held_q <= decoded;
            pc_q   <= fetch_pc;
         end
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for the decode stage with hand-computed expectations
module tb_decode_stage;
   import instruction::*;
   logic          clk = 1'b0;
   logic          rst, fetch_valid, fetch_ready, flush, issue_valid, issue_ready;
   logic          writeback_valid;
   logic [31:0]   fetch_instruction, fetch_pc, issue_pc, stall_count;
   logic [4:0]    writeback_rd;
   instruction::t issue_instruction;
   int            n_cmp = 0;
   int            n_err = 0;

   decode_stage #(.COUNTER_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_instruction(issue_instruction), .issue_pc(issue_pc),
      .writeback_valid(writeback_valid), .writeback_rd(writeback_rd),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      fetch_valid       = v;
      fetch_instruction = ins;
      fetch_pc          = pc;
   endtask

   task automatic wb(input logic v, input logic [4:0] rd);
      writeback_valid = v;
      writeback_rd    = rd;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; issue_ready = 1'b1;
      fetch(1'b0, 32'h0, 32'h0);
      wb(1'b0, 5'd0);
      #2;
      chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      cyc(); cyc();
      rst = 1'b0;
      #2;
      chk("post_rst_fetch_ready", 32'(fetch_ready), 32'd1);
      chk("post_rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("post_rst_stall", stall_count, 32'd0);
      chk("post_rst_busy", dut.busy_q, 32'd0);

      // back-to-back: ADDI x1, NOP, XORI x1 (NOP in between lets x1 retire)
      fetch(1'b1, 32'h06410093, 32'h100);
      #2; chk("b2b_accept", 32'(fetch_ready), 32'd1);
      cyc();
      fetch(1'b1, 32'h00000013, 32'h104);
      #2;
      chk("b2b_addi_valid", 32'(issue_valid), 32'd1);
      chk("b2b_addi_op", 32'(issue_instruction.op), 32'(ADDI));
      chk("b2b_addi_imm", issue_instruction.immediate, 32'd100);
      chk("b2b_addi_rd", 32'(issue_instruction.rd_address), 32'd1);
      chk("b2b_addi_pc", issue_pc, 32'h100);
      chk("b2b_ready", 32'(fetch_ready), 32'd1);
      cyc();
      fetch(1'b1, 32'h0FF14093, 32'h108);
      wb(1'b1, 5'd1);
      #2;
      chk("b2b_nop_valid", 32'(issue_valid), 32'd1);
      chk("b2b_nop_pc", issue_pc, 32'h104);
      cyc();
      fetch(1'b0, 32'h0, 32'h0);
      wb(1'b0, 5'd0);
      #2;
      chk("b2b_xori_valid", 32'(issue_valid), 32'd1);
      chk("b2b_xori_op", 32'(issue_instruction.op), 32'(XORI));
      chk("b2b_xori_imm", issue_instruction.immediate, 32'h0FF);
      chk("b2b_busy_clear", dut.busy_q, 32'd0);
      cyc();
      wb(1'b1, 5'd1);
      #2;
      chk("b2b_busy_x1", dut.busy_q, 32'h2);
      chk("b2b_idle", 32'(issue_valid), 32'd0);
      cyc();
      wb(1'b0, 5'd0);
      #2;
      chk("b2b_busy_end", dut.busy_q, 32'd0);
      chk("b2b_stall", stall_count, 32'd0);

      // RAW: LW x1 then ADD x3,x1,x2; x1 writeback after four stalled cycles
      fetch(1'b1, 32'h00412083, 32'h200);
      cyc();
      fetch(1'b1, 32'h002081B3, 32'h204);
      #2; chk("raw_lw_op", 32'(issue_instruction.op), 32'(LW));
      cyc();
      fetch(1'b0, 32'h0, 32'h0);
      #2;
      chk("raw_held_valid", 32'(issue_valid), 32'd0);
      chk("raw_held_ready", 32'(fetch_ready), 32'd0);
      cyc(); cyc(); cyc();
      wb(1'b1, 5'd1);
      #2;
      chk("raw_no_bypass", 32'(issue_valid), 32'd0);
      chk("raw_stall_3", stall_count, 32'd3);
      cyc();
      wb(1'b0, 5'd0);
      #2;
      chk("raw_issue", 32'(issue_valid), 32'd1);
      chk("raw_add_op", 32'(issue_instruction.op), 32'(ADD));
      chk("raw_add_pc", issue_pc, 32'h204);
      chk("raw_stall_4", stall_count, 32'd4);
      cyc();
      wb(1'b1, 5'd3);
      cyc();
      wb(1'b0, 5'd0);

      // serialisation: CSRRW behind ADD x1, then ECALL behind ADD x5
      fetch(1'b1, 32'h003100B3, 32'h300);
      cyc();
      fetch(1'b1, 32'h300110F3, 32'h304);
      #2; chk("ser_add_issue", 32'(issue_valid), 32'd1);
      cyc();
      fetch(1'b0, 32'h0, 32'h0);
      #2; chk("ser_csr_block", 32'(issue_valid), 32'd0);
      cyc();
      wb(1'b1, 5'd1);
      #2; chk("ser_csr_block2", 32'(issue_valid), 32'd0);
      cyc();
      wb(1'b0, 5'd0);
      #2;
      chk("ser_csr_issue", 32'(issue_valid), 32'd1);
      chk("ser_csr_op", 32'(issue_instruction.op), 32'(CSRRW));
      chk("ser_csr_addr", 32'(issue_instruction.csr), 32'h300);
      chk("ser_stall", stall_count, 32'd6);
      cyc();
      fetch(1'b1, 32'h003102B3, 32'h308);
      wb(1'b1, 5'd1);
      cyc();
      fetch(1'b1, 32'h00000073, 32'h30C);
      wb(1'b0, 5'd0);
      #2; chk("ser_add5_issue", 32'(issue_valid), 32'd1);
      cyc();
      fetch(1'b0, 32'h0, 32'h0);
      wb(1'b1, 5'd5);
      #2; chk("ser_ecall_block", 32'(issue_valid), 32'd0);
      cyc();
      wb(1'b0, 5'd0);
      #2;
      chk("ser_ecall_issue", 32'(issue_valid), 32'd1);
      chk("ser_ecall_op", 32'(issue_instruction.op), 32'(ECALL));
      chk("ser_stall2", stall_count, 32'd7);
      cyc();

      // flush while SUB is held and fetch offers another instruction
      fetch(1'b1, 32'h003102B3, 32'h400);
      cyc();
      fetch(1'b1, 32'h403100B3, 32'h404);
      cyc();
      issue_ready = 1'b0;
      fetch(1'b1, 32'h06410093, 32'h408);
      #2;
      chk("fl_sub_valid", 32'(issue_valid), 32'd1);
      chk("fl_sub_op", 32'(issue_instruction.op), 32'(SUB));
      chk("fl_sub_ready", 32'(fetch_ready), 32'd0);
      cyc();
      flush = 1'b1;
      issue_ready = 1'b1;
      #2;
      chk("fl_issue_valid", 32'(issue_valid), 32'd0);
      chk("fl_fetch_ready", 32'(fetch_ready), 32'd0);
      cyc();
      flush = 1'b0;
      fetch(1'b0, 32'h0, 32'h0);
      #2;
      chk("fl_held", 32'(dut.held_valid_q), 32'd0);
      chk("fl_ready_after", 32'(fetch_ready), 32'd1);
      chk("fl_busy_kept", dut.busy_q, 32'h20);
      chk("fl_stall", stall_count, 32'd7);
      wb(1'b1, 5'd5);
      cyc();
      wb(1'b0, 5'd0);

      // illegal issues despite busy[31]; neither it nor ADDI x0 sets a busy bit
      fetch(1'b1, 32'h00100F93, 32'h500);
      cyc();
      fetch(1'b1, 32'hFFFFFFFF, 32'h504);
      cyc();
      fetch(1'b1, 32'h00000013, 32'h508);
      #2;
      chk("ill_issue", 32'(issue_valid), 32'd1);
      chk("ill_op", 32'(issue_instruction.op), 32'(ILLEGAL));
      cyc();
      fetch(1'b0, 32'h0, 32'h0);
      #2;
      chk("x0_issue", 32'(issue_valid), 32'd1);
      chk("ill_busy", dut.busy_q, 32'h8000_0000);
      cyc();
      wb(1'b1, 5'd31);
      #2;
      chk("x0_busy", dut.busy_q, 32'h8000_0000);
      chk("ill_stall", stall_count, 32'd7);
      cyc();
      wb(1'b0, 5'd0);

      // reset while ADD x3 is stalled on busy[1]
      fetch(1'b1, 32'h00412083, 32'h600);
      cyc();
      fetch(1'b1, 32'h002081B3, 32'h604);
      cyc();
      fetch(1'b0, 32'h0, 32'h0);
      #2;
      chk("mr_stalled", 32'(issue_valid), 32'd0);
      chk("mr_stall_7", stall_count, 32'd7);
      chk("mr_busy", dut.busy_q, 32'h2);
      rst = 1'b1;
      #2;
      chk("mr_rst_ready", 32'(fetch_ready), 32'd0);
      cyc();
      rst = 1'b0;
      #2;
      chk("mr_held", 32'(dut.held_valid_q), 32'd0);
      chk("mr_issue_valid", 32'(issue_valid), 32'd0);
      chk("mr_fetch_ready", 32'(fetch_ready), 32'd1);
      chk("mr_busy_clear", dut.busy_q, 32'd0);
      chk("mr_stall_clear", stall_count, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
